// File: rtl/decode_stage.sv
// ID stage of a five-stage MIPS-style pipeline: register file with write-through
// bypass, immediate extension, load-use hazard detection and the ID/EX register.
module decode_stage #(
   parameter int len      = 32,
   parameter int nregs    = 32,
   parameter int zero_reg = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [len-1:0]           in_instruccion,
   input  logic [len-1:0]           in_pc,
   input  logic                     RegWrite,
   input  logic [$clog2(nregs)-1:0] write_register,
   input  logic [len-1:0]           write_data,
   input  logic                     in_idex_mem_read,
   input  logic [$clog2(nregs)-1:0] in_idex_rt,
   input  logic                     in_flush,
   output logic [len-1:0]           out_reg1,
   output logic [len-1:0]           out_reg2,
   output logic [len-1:0]           out_imm,
   output logic [$clog2(nregs)-1:0] out_rs,
   output logic [$clog2(nregs)-1:0] out_rt,
   output logic [$clog2(nregs)-1:0] out_rd,
   output logic [len-1:0]           out_pc,
   output logic                     out_valid,
   output logic                     out_stall
);

   localparam int aw = $clog2(nregs);

   logic [len-1:0] regs [nregs];
   logic [aw-1:0]  rs;
   logic [aw-1:0]  rt;
   logic [aw-1:0]  rd;
   logic [5:0]     opcode;
   logic           zero_ext;
   logic [len-1:0] imm;
   logic [len-1:0] rd1;
   logic [len-1:0] rd2;
   logic           wr_allowed;

   // Register fields are 5 bits in the encoding; fit them to the address width.
   if (aw > 5) begin : g_pad
      assign rs = {{(aw-5){1'b0}}, in_instruccion[25:21]};
      assign rt = {{(aw-5){1'b0}}, in_instruccion[20:16]};
      assign rd = {{(aw-5){1'b0}}, in_instruccion[15:11]};
   end else begin : g_trunc
      assign rs = in_instruccion[21 +: aw];
      assign rt = in_instruccion[16 +: aw];
      assign rd = in_instruccion[11 +: aw];
   end

   assign opcode   = in_instruccion[31:26];
   assign zero_ext = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
   assign imm      = zero_ext ? {{(len-16){1'b0}}, in_instruccion[15:0]}
                              : {{(len-16){in_instruccion[15]}}, in_instruccion[15:0]};

   assign wr_allowed = RegWrite && !((zero_reg != 0) && (write_register == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < nregs; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_allowed) begin
         regs[write_register] <= write_data;
      end
   end

   // Writeback in the same cycle as the read is forwarded so ID never sees stale data.
   always_comb begin
      rd1 = regs[rs];
      rd2 = regs[rt];
      if (RegWrite && (write_register == rs)) rd1 = write_data;
      if (RegWrite && (write_register == rt)) rd2 = write_data;
      if ((zero_reg != 0) && (rs == '0)) rd1 = '0;
      if ((zero_reg != 0) && (rt == '0)) rd2 = '0;
   end

   assign out_stall = in_idex_mem_read
                      && ((in_idex_rt == rs) || (in_idex_rt == rt))
                      && !((zero_reg != 0) && (in_idex_rt == '0));

   always_ff @(posedge clk) begin
      if (reset || out_stall || in_flush) begin
         out_reg1  <= '0;
         out_reg2  <= '0;
         out_imm   <= '0;
         out_rs    <= '0;
         out_rt    <= '0;
         out_rd    <= '0;
         out_pc    <= '0;
         out_valid <= 1'b0;
      end else begin
         out_reg1  <= rd1;
         out_reg2  <= rd2;
         out_imm   <= imm;
         out_rs    <= rs;
         out_rt    <= rt;
         out_rd    <= rd;
         out_pc    <= in_pc;
         out_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: one instance with zero_reg=1 and one with zero_reg=0
// share stimulus and are checked against an array-based register model.
module tb_decode_stage;

   localparam int LEN   = 32;
   localparam int NREGS = 32;

   typedef struct packed {
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        valid;
   } idex_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        reg_write;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;
   logic        mem_read;
   logic [4:0]  idex_rt;
   logic        flush;

   logic [31:0] a_reg1, a_reg2, a_imm, a_pc, b_reg1, b_reg2, b_imm, b_pc;
   logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
   logic        a_valid, a_stall, b_valid, b_stall;
   idex_t       obs1, obs0, exp1, exp0;

   logic [31:0] m1 [NREGS];
   logic [31:0] m0 [NREGS];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   decode_stage #(.len(LEN), .nregs(NREGS), .zero_reg(1)) dut1 (
      .clk(clk), .reset(reset), .in_instruccion(instr), .in_pc(pc),
      .RegWrite(reg_write), .write_register(wr_reg), .write_data(wr_data),
      .in_idex_mem_read(mem_read), .in_idex_rt(idex_rt), .in_flush(flush),
      .out_reg1(a_reg1), .out_reg2(a_reg2), .out_imm(a_imm), .out_rs(a_rs),
      .out_rt(a_rt), .out_rd(a_rd), .out_pc(a_pc), .out_valid(a_valid),
      .out_stall(a_stall));

   decode_stage #(.len(LEN), .nregs(NREGS), .zero_reg(0)) dut0 (
      .clk(clk), .reset(reset), .in_instruccion(instr), .in_pc(pc),
      .RegWrite(reg_write), .write_register(wr_reg), .write_data(wr_data),
      .in_idex_mem_read(mem_read), .in_idex_rt(idex_rt), .in_flush(flush),
      .out_reg1(b_reg1), .out_reg2(b_reg2), .out_imm(b_imm), .out_rs(b_rs),
      .out_rt(b_rt), .out_rd(b_rd), .out_pc(b_pc), .out_valid(b_valid),
      .out_stall(b_stall));

   assign obs1 = {a_reg1, a_reg2, a_imm, a_rs, a_rt, a_rd, a_pc, a_valid};
   assign obs0 = {b_reg1, b_reg2, b_imm, b_rs, b_rt, b_rd, b_pc, b_valid};

   function automatic logic [31:0] model_read(bit zr, logic [4:0] a);
      if (zr && a == 5'd0) return 32'd0;
      if (reg_write && wr_reg == a) return wr_data;
      return zr ? m1[a] : m0[a];
   endfunction

   function automatic bit model_stall(bit zr);
      if (!mem_read) return 1'b0;
      if (zr && idex_rt == 5'd0) return 1'b0;
      return (idex_rt == instr[25:21]) || (idex_rt == instr[20:16]);
   endfunction

   function automatic idex_t predict(bit zr);
      idex_t e;
      int    op;
      e  = '0;
      op = int'(instr[31:26]);
      if (reset || flush || model_stall(zr)) return e;
      e.r1    = model_read(zr, instr[25:21]);
      e.r2    = model_read(zr, instr[20:16]);
      e.imm   = (op >= 12 && op <= 14) ? {16'd0, instr[15:0]}
                                       : 32'($signed(instr[15:0]));
      e.rs    = instr[25:21];
      e.rt    = instr[20:16];
      e.rd    = instr[15:11];
      e.pc    = pc;
      e.valid = 1'b1;
      return e;
   endfunction

   // Predicts from pre-edge inputs, advances one clock, then updates the model.
   task automatic cycle();
      exp1 = predict(1'b1);
      exp0 = predict(1'b0);
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            m1[i] = 32'd0;
            m0[i] = 32'd0;
         end
      end else if (reg_write) begin
         if (wr_reg != 5'd0) m1[wr_reg] = wr_data;
         m0[wr_reg] = wr_data;
      end
      #1;
   endtask

   task automatic idle_inputs();
      reset = 0; instr = 0; pc = 0; reg_write = 0; wr_reg = 0; wr_data = 0;
      mem_read = 0; idex_rt = 0; flush = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1; pc = 32'h1234; instr = 32'h8C22D905;
      cycle();
      tests++;
      if (obs1 !== 144'd0) begin
         fails++; $display("[TB] FAIL reset_z1: got %h want 0", obs1);
      end
      tests++;
      if (obs0 !== 144'd0) begin
         fails++; $display("[TB] FAIL reset_z0: got %h want 0", obs0);
      end
      reset = 0;
   endtask

   task automatic test_write_read();
      idle_inputs();
      reg_write = 1; wr_reg = 1; wr_data = 7;
      cycle();
      wr_reg = 2; wr_data = 4;
      cycle();
      reg_write = 0; instr = 32'h8C22D905; pc = 32'h0000_0104;
      cycle();
      tests++;
      if (a_reg1 !== 32'd7 || a_reg2 !== 32'd4 || a_imm !== 32'hFFFFD905 || a_valid !== 1'b1) begin
         fails++;
         $display("[TB] FAIL write_read: got r1=%h r2=%h imm=%h v=%b want 7 4 ffffd905 1",
                  a_reg1, a_reg2, a_imm, a_valid);
      end
      tests++;
      if (obs1 !== exp1) begin
         fails++; $display("[TB] FAIL write_read_full: got %h want %h", obs1, exp1);
      end
   endtask

   task automatic test_zero_reg();
      idle_inputs();
      reg_write = 1; wr_reg = 0; wr_data = 4;
      cycle();
      reg_write = 0; instr = 32'h0000_0000;
      cycle();
      tests++;
      if (a_reg1 !== 32'd0) begin
         fails++; $display("[TB] FAIL zero_reg_on: got %h want 0", a_reg1);
      end
      tests++;
      if (b_reg1 !== 32'd4) begin
         fails++; $display("[TB] FAIL zero_reg_off: got %h want 4", b_reg1);
      end
   endtask

   task automatic test_bypass();
      idle_inputs();
      reg_write = 1; wr_reg = 3; wr_data = 32'h55; instr = 32'h0060_0000;
      cycle();
      tests++;
      if (a_reg1 !== 32'h55 || b_reg1 !== 32'h55) begin
         fails++; $display("[TB] FAIL bypass: got %h/%h want 55", a_reg1, b_reg1);
      end
      reg_write = 0; instr = 32'h0003_0000;
      cycle();
      tests++;
      if (a_reg2 !== 32'h55) begin
         fails++; $display("[TB] FAIL bypass_stored: got %h want 55", a_reg2);
      end
   endtask

   task automatic test_imm_ext();
      idle_inputs();
      instr = 32'h3421F00F;
      cycle();
      tests++;
      if (a_imm !== 32'h0000F00F) begin
         fails++; $display("[TB] FAIL zero_ext_ori: got %h want 0000f00f", a_imm);
      end
      instr = 32'h2021F00F;
      cycle();
      tests++;
      if (a_imm !== 32'hFFFFF00F) begin
         fails++; $display("[TB] FAIL sign_ext_addi: got %h want fffff00f", a_imm);
      end
      instr = 32'h3821800F;
      cycle();
      tests++;
      if (a_imm !== 32'h0000800F) begin
         fails++; $display("[TB] FAIL zero_ext_xori: got %h want 0000800f", a_imm);
      end
   endtask

   task automatic test_load_use();
      idle_inputs();
      mem_read = 1; idex_rt = 2; instr = 32'h8C22D905;
      #1;
      tests++;
      if (a_stall !== 1'b1 || b_stall !== 1'b1) begin
         fails++; $display("[TB] FAIL load_use_stall: got %b/%b want 1/1", a_stall, b_stall);
      end
      cycle();
      tests++;
      if (a_valid !== 1'b0 || obs1 !== 144'd0) begin
         fails++; $display("[TB] FAIL load_use_bubble: got %h want 0", obs1);
      end
      idex_rt = 0; instr = 32'h0000_1234;
      #1;
      tests++;
      if (a_stall !== 1'b0 || b_stall !== 1'b1) begin
         fails++; $display("[TB] FAIL load_use_r0: got %b/%b want 0/1", a_stall, b_stall);
      end
      cycle();
      tests++;
      if (a_valid !== 1'b1 || b_valid !== 1'b0) begin
         fails++; $display("[TB] FAIL load_use_r0_valid: got %b/%b want 1/0", a_valid, b_valid);
      end
   endtask

   task automatic test_flush();
      idle_inputs();
      flush = 1; instr = 32'h8C22D905; pc = 32'h200;
      cycle();
      tests++;
      if (obs1 !== 144'd0 || obs0 !== 144'd0) begin
         fails++; $display("[TB] FAIL flush_bubble: got %h want 0", obs1);
      end
      mem_read = 1; idex_rt = 1;
      #1;
      tests++;
      if (a_stall !== 1'b1) begin
         fails++; $display("[TB] FAIL flush_stall_flag: got %b want 1", a_stall);
      end
      cycle();
      tests++;
      if (a_valid !== 1'b0 || obs1 !== 144'd0) begin
         fails++; $display("[TB] FAIL flush_stall_bubble: got %h want 0", obs1);
      end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      reg_write = 1; wr_reg = 1; wr_data = 7;
      cycle();
      wr_reg = 2; wr_data = 4; instr = 32'h0022_0000; pc = 32'h44;
      cycle();
      reset = 1; reg_write = 1; wr_reg = 5; wr_data = 32'hDEAD; flush = 1;
      mem_read = 1; idex_rt = 1; instr = 32'h0020_0000;
      #1;
      tests++;
      if (a_stall !== 1'b1) begin
         fails++; $display("[TB] FAIL stall_during_reset: got %b want 1", a_stall);
      end
      cycle();
      tests++;
      if (obs1 !== 144'd0 || obs0 !== 144'd0) begin
         fails++; $display("[TB] FAIL reset_mid_outputs: got %h want 0", obs1);
      end
      idle_inputs();
      instr = 32'h00A1_0000;
      cycle();
      tests++;
      if (a_reg1 !== 32'd0 || a_reg2 !== 32'd0 || b_reg1 !== 32'd0 || a_valid !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_mid_regs: got r5=%h r1=%h v=%b want 0 0 1", a_reg1, a_reg2, a_valid);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         instr     = $urandom;
         if ($urandom_range(0, 3) == 0) instr[31:26] = 6'($urandom_range(12, 14));
         pc        = $urandom;
         reg_write = ($urandom_range(0, 1) == 1);
         wr_reg    = 5'($urandom);
         if ($urandom_range(0, 3) == 0) wr_reg = instr[25:21];
         if ($urandom_range(0, 7) == 0) wr_reg = 5'd0;
         wr_data   = $urandom;
         mem_read  = ($urandom_range(0, 3) == 0);
         idex_rt   = ($urandom_range(0, 1) == 1) ? instr[20:16] : 5'($urandom);
         if ($urandom_range(0, 7) == 0) idex_rt = 5'd0;
         flush     = ($urandom_range(0, 9) == 0);
         reset     = ($urandom_range(0, 39) == 0);
         #1;
         tests++;
         if (a_stall !== model_stall(1'b1) || b_stall !== model_stall(1'b0)) begin
            fails++;
            $display("[TB] FAIL rand_stall[%0d]: got %b/%b want %b/%b", n, a_stall, b_stall,
                     model_stall(1'b1), model_stall(1'b0));
         end
         cycle();
         tests++;
         if (obs1 !== exp1 || obs0 !== exp0) begin
            fails++;
            $display("[TB] FAIL rand_idex[%0d]: got %h/%h want %h/%h", n, obs1, obs0, exp1, exp0);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NREGS; i++) begin
         m1[i] = 32'd0;
         m0[i] = 32'd0;
      end
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_write_read();
      test_zero_reg();
      test_bypass();
      test_imm_ext();
      test_load_use();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter len, default 32, SHALL set the data and instruction width in bits.
REQ-002 Parameter nregs, default 32, SHALL set the register count; the address width SHALL be $clog2(nregs).
REQ-003 Parameter zero_reg, default 1, SHALL make register 0 read as zero and ignore writes to it when 1, and SHALL make register 0 ordinary when 0.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-006 in_instruccion  in  len  SHALL carry the instruction word to decode.
REQ-007 in_pc  in  len  SHALL carry the PC+4 of the instruction.
REQ-008 RegWrite  in  1  SHALL be the writeback enable.
REQ-009 write_register  in  $clog2(nregs)  SHALL be the writeback address.
REQ-010 write_data  in  len  SHALL be the writeback data.
REQ-011 in_idex_mem_read  in  1  SHALL flag that the instruction now in EX is a load.
REQ-012 in_idex_rt  in  $clog2(nregs)  SHALL be the destination of the instruction now in EX.
REQ-013 in_flush  in  1  SHALL request a bubble into ID/EX on a taken branch or jump.
REQ-014 out_reg1, out_reg2  out  len each  SHALL be the registered rs and rt operands.
REQ-015 out_imm  out  len  SHALL be the registered extended immediate.
REQ-016 out_rs, out_rt, out_rd  out  $clog2(nregs) each  SHALL be the registered register fields.
REQ-017 out_pc  out  len  SHALL be the registered in_pc.
REQ-018 out_valid  out  1  SHALL be 1 for a real instruction in ID/EX and 0 for a bubble.
REQ-019 out_stall  out  1  SHALL be the combinational load-use stall request to IF.

Function
REQ-020 Fields: rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], opcode = instr[31:26], each truncated or zero-padded to the address width.
REQ-021 Register write: on a rising edge with RegWrite=1, reg[write_register] SHALL take write_data, except address 0 when zero_reg=1.
REQ-022 A register read SHALL be combinational, with a write-through bypass: when RegWrite=1 and write_register equals the read address, the read value SHALL be write_data. Under zero_reg=1, address 0 SHALL read 0 regardless.
REQ-023 Immediate: opcodes 0x0C, 0x0D and 0x0E SHALL zero-extend instr[15:0]; all other opcodes SHALL sign-extend it to len.
REQ-024 out_stall SHALL be in_idex_mem_read && (in_idex_rt==rs || in_idex_rt==rt) && !(zero_reg && in_idex_rt==0).
REQ-025 ID/EX: each edge with no reset, no flush and no stall SHALL load all decoded fields, the operands and in_pc, and SHALL set out_valid=1; latency is 1 cycle.
REQ-026 On an edge with out_stall=1 or in_flush=1, ID/EX SHALL load a bubble: every output register 0 and out_valid=0.
REQ-027 When flush and stall are both active, the result SHALL be a bubble, with out_stall still asserted.
REQ-028 A writeback and a read of the same register in the same cycle SHALL latch the new value into ID/EX through the bypass.

Reset
REQ-029 On an edge with reset=1, all nregs registers SHALL become 0.
REQ-030 On an edge with reset=1, all ID/EX outputs SHALL become 0, including out_valid.
REQ-031 Reset SHALL take priority over write, flush and stall, including when it is asserted mid-operation.
REQ-032 out_stall SHALL depend only on its inputs and not on reset.

Verification
REQ-033 Write and read: write r1=7 and r2=4 with RegWrite=1, then instr 0x8C22D905 -> after 1 cycle out_reg1=7, out_reg2=4, out_imm=0xFFFFD905, out_valid=1.
REQ-034 Zero register: with zero_reg=1, write r0=4, then read rs=0 -> out_reg1=0. With zero_reg=0 the same sequence -> out_reg1=4.
REQ-035 Bypass: RegWrite=1, write_register=3, write_data=0x55 in the same cycle as decoding rs=3 -> out_reg1=0x55 next cycle.
REQ-036 Zero extension: instr 0x3421F00F (ori) -> out_imm=0x0000F00F.
REQ-037 Load-use: in_idex_mem_read=1, in_idex_rt=2, instr rt=2 -> out_stall=1 the same cycle and out_valid=0 next cycle. With in_idex_rt=0 and zero_reg=1 -> out_stall=0.
REQ-038 Flush and reset: in_flush=1 -> bubble next cycle. reset=1 after the writes of REQ-033 -> r1 reads 0 and all outputs are 0 next cycle.
